// File: rtl/mux_serializer_pkg.sv
// Shared state encodings, widths and select-index limits for mux_serializer.
// The PAR encoding is reserved even when MUX_SER_PARITY_EN is left undefined.
package mux_serializer_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned SEL_W  = 4;

  localparam logic [SEL_W-1:0] SEL_MIN = 4'd0;
  localparam logic [SEL_W-1:0] SEL_MAX = 4'd15;

  // Terminal indices for each scan direction
  localparam logic [SEL_W-1:0] SEL_TERM_LSB_FIRST = SEL_MAX;
  localparam logic [SEL_W-1:0] SEL_TERM_MSB_FIRST = SEL_MIN;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } ser_state_e;

  function automatic logic [SEL_W-1:0] step_sel(input logic [SEL_W-1:0] sel,
                                                input bit              down);
    return down ? (sel - SEL_W'(1)) : (sel + SEL_W'(1));
  endfunction

endpackage

// File: rtl/mux_serializer_mux16x1.sv
// 16-to-1 bit multiplexer: Y is D bit S.
module mux16x1 (
  input  logic [15:0] D,
  input  logic [3:0]  S,
  output logic        Y
);

  assign Y = D[S];

endmodule

// File: rtl/mux_serializer.sv
// Serializes a 16-bit word through mux16x1 with valid/ready handshaking.
// Optional trailing even-parity bit when MUX_SER_PARITY_EN is defined.
module mux_serializer
  import mux_serializer_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  output logic [3:0]  sel,
  output logic        ser_out,
  output logic        ser_valid,
  input  logic        ser_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [SEL_W-1:0] SEL_START = MSB_FIRST ? SEL_MAX : SEL_MIN;
  localparam logic [SEL_W-1:0] SEL_TERM  = MSB_FIRST ? SEL_TERM_MSB_FIRST
                                                     : SEL_TERM_LSB_FIRST;

  ser_state_e         state_q, state_d;
  logic [WORD_W-1:0]  word_q,  word_d;
  logic [SEL_W-1:0]   sel_q,   sel_d;
  logic               done_q,  done_d;
  logic               mux_y;

  mux16x1 u_mux (
    .D (word_q),
    .S (sel_q),
    .Y (mux_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      sel_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      sel_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (load_valid) begin
            word_d  = load_data;
            sel_d   = SEL_START;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (ser_ready) begin
            // sel stays at the terminal index on exit; it never wraps
            if (sel_q == SEL_TERM) begin
`ifdef MUX_SER_PARITY_EN
              state_d = ST_PAR;
`else
              state_d = ST_IDLE;
              done_d  = 1'b1;
`endif
            end else begin
              sel_d = step_sel(sel_q, MSB_FIRST);
            end
          end
        end
`ifdef MUX_SER_PARITY_EN
        ST_PAR: begin
          if (ser_ready) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ser_out = 1'b0;
    unique case (state_q)
      ST_SHIFT: ser_out = mux_y;
`ifdef MUX_SER_PARITY_EN
      ST_PAR:   ser_out = ^word_q;
`endif
      default:  ser_out = 1'b0;
    endcase
  end

  assign load_ready = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
`ifdef MUX_SER_PARITY_EN
  assign ser_valid  = (state_q == ST_SHIFT) || (state_q == ST_PAR);
`else
  assign ser_valid  = (state_q == ST_SHIFT);
`endif
  assign sel        = sel_q;
  assign done       = done_q;

endmodule

// File: tb/tb_mux_serializer.sv
// Self-checking bench: drives an LSB-first and an MSB-first instance in lockstep
// and compares both against a bit-queue model of the word.
module tb_mux_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        load_valid;
  logic [15:0] load_data;
  logic        ser_ready;

  logic        load_ready0, ser_out0, ser_valid0, busy0, done0;
  logic        load_ready1, ser_out1, ser_valid1, busy1, done1;
  logic [3:0]  sel0, sel1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mux_serializer #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready0), .sel(sel0),
    .ser_out(ser_out0), .ser_valid(ser_valid0), .ser_ready(ser_ready),
    .busy(busy0), .done(done0)
  );

  mux_serializer #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready1), .sel(sel1),
    .ser_out(ser_out1), .ser_valid(ser_valid1), .ser_ready(ser_ready),
    .busy(busy1), .done(done1)
  );

  // mode 0: ready always 1; mode 1: random ready; mode 2: ready pattern 1,0,0,1 then 1
  task automatic run_word(input logic [15:0] w, input int mode,
                          input bit inject, input bit chain);
    bit e0[$];
    bit e1[$];
    int n;
    int cnt;
    int cyc;
    bit rdy;
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 16; i++) begin
      e0.push_back(w[i]);
      e1.push_back(w[15-i]);
    end
`ifdef MUX_SER_PARITY_EN
    e0.push_back(^w);
    e1.push_back(^w);
`endif
    n = e0.size();

    load_data  = w;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    load_data  = 16'($urandom);
    cnt = 0;
    cyc = 0;
    while (cnt < n && cyc < 400) begin
      tests++;
      if (ser_valid0 !== 1'b1 || ser_valid1 !== 1'b1) begin
        fails++;
        $display("FAIL ser_valid w=%h bit=%0d got=%b/%b exp=1/1", w, cnt, ser_valid0, ser_valid1);
      end
      tests++;
      if (ser_out0 !== e0[cnt]) begin
        fails++;
        $display("FAIL ser_out_lsb w=%h bit=%0d got=%b exp=%b", w, cnt, ser_out0, e0[cnt]);
      end
      tests++;
      if (ser_out1 !== e1[cnt]) begin
        fails++;
        $display("FAIL ser_out_msb w=%h bit=%0d got=%b exp=%b", w, cnt, ser_out1, e1[cnt]);
      end
      if (cnt < 16) begin
        tests++;
        if (sel0 !== 4'(cnt) || sel1 !== 4'(15 - cnt)) begin
          fails++;
          $display("FAIL sel w=%h bit=%0d got=%0d/%0d exp=%0d/%0d", w, cnt, sel0, sel1, cnt, 15 - cnt);
        end
      end
      tests++;
      if ({busy0, load_ready0, done0, busy1, load_ready1, done1} !== 6'b100100) begin
        fails++;
        $display("FAIL busy_flags w=%h bit=%0d got=%b exp=100100", w, cnt,
                 {busy0, load_ready0, done0, busy1, load_ready1, done1});
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (cyc < 4) ? pat[cyc] : 1'b1;
      endcase
      load_valid = inject && cnt >= 3 && cnt < 8;
      load_data  = ~w;
      ser_ready  = rdy;
      @(negedge clk);
      if (rdy) cnt++;
      cyc++;
    end
    load_valid = 1'b0;
    ser_ready  = 1'b0;
    tests++;
    if (cnt < n) begin
      fails++;
      $display("FAIL timeout w=%h got=%0d transfers exp=%0d", w, cnt, n);
    end
    tests++;
    if ({done0, load_ready0, busy0, ser_valid0, ser_out0} !== 5'b11000 ||
        {done1, load_ready1, busy1, ser_valid1, ser_out1} !== 5'b11000) begin
      fails++;
      $display("FAIL end_of_word w=%h got=%b/%b exp=11000/11000", w,
               {done0, load_ready0, busy0, ser_valid0, ser_out0},
               {done1, load_ready1, busy1, ser_valid1, ser_out1});
    end
    if (!chain) begin
      @(negedge clk);
      tests++;
      if (done0 !== 1'b0 || done1 !== 1'b0) begin
        fails++;
        $display("FAIL done_single_pulse w=%h got=%b/%b exp=0/0", w, done0, done1);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; load_valid = 1'b0; load_data = '0; ser_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({load_ready0, ser_valid0, ser_out0, busy0, done0, sel0} !== 9'b100000000 ||
        {load_ready1, ser_valid1, ser_out1, busy1, done1, sel1} !== 9'b100000000) begin
      fails++;
      $display("FAIL reset_state got=%b/%b exp=100000000",
               {load_ready0, ser_valid0, ser_out0, busy0, done0, sel0},
               {load_ready1, ser_valid1, ser_out1, busy1, done1, sel1});
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({load_ready0, ser_valid0, ser_out0, busy0, done0} !== 5'b10000 ||
        {load_ready1, ser_valid1, ser_out1, busy1, done1} !== 5'b10000) begin
      fails++;
      $display("FAIL after_reset got=%b/%b exp=10000",
               {load_ready0, ser_valid0, ser_out0, busy0, done0},
               {load_ready1, ser_valid1, ser_out1, busy1, done1});
    end
  endtask

  task automatic test_fixed_word();
    run_word(16'b1001101001101001, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_word(16'b1001101001101001, 2, 1'b0, 1'b0);
    run_word(16'hC3A5, 2, 1'b0, 1'b0);
  endtask

  task automatic test_load_ignored();
    run_word(16'h5A0F, 0, 1'b1, 1'b0);
    run_word(16'h1234, 1, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) run_word(16'($urandom), 1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_word(16'hBEEF, 0, 1'b0, 1'b1);
    run_word(16'h0F0F, 0, 1'b0, 1'b1);
    run_word(16'h8001, 1, 1'b0, 1'b0);
  endtask

  task automatic test_parity();
    run_word(16'h0001, 0, 1'b0, 1'b0);
    run_word(16'hFFFF, 1, 1'b0, 1'b0);
  endtask

  task automatic test_clear();
    load_data = 16'b1001101001101001; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; ser_ready = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if (sel0 !== 4'd5 || busy0 !== 1'b1) begin
      fails++;
      $display("FAIL clear_setup got sel=%0d busy=%b exp sel=5 busy=1", sel0, busy0);
    end
    clear = 1'b1; load_valid = 1'b1; load_data = 16'hFFFF;
    @(negedge clk);
    clear = 1'b0; load_valid = 1'b0; ser_ready = 1'b0;
    tests++;
    if ({load_ready0, busy0, ser_valid0, ser_out0, done0, sel0} !== 9'b100000000 ||
        {load_ready1, busy1, ser_valid1, ser_out1, done1, sel1} !== 9'b100000000) begin
      fails++;
      $display("FAIL clear_to_idle got=%b/%b exp=100000000",
               {load_ready0, busy0, ser_valid0, ser_out0, done0, sel0},
               {load_ready1, busy1, ser_valid1, ser_out1, done1, sel1});
    end
    @(negedge clk);
    tests++;
    if (done0 !== 1'b0 || done1 !== 1'b0) begin
      fails++;
      $display("FAIL clear_no_done got=%b/%b exp=0/0", done0, done1);
    end
    clear = 1'b1; load_valid = 1'b1; load_data = 16'h1111;
    @(negedge clk);
    clear = 1'b0; load_valid = 1'b0;
    tests++;
    if (load_ready0 !== 1'b1 || busy1 !== 1'b0) begin
      fails++;
      $display("FAIL clear_beats_load got ready=%b busy=%b exp ready=1 busy=0", load_ready0, busy1);
    end
    run_word(16'h6C93, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midword();
    load_data = 16'hA5C3; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; ser_ready = 1'b1;
    repeat (5) @(negedge clk);
    ser_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({load_ready0, busy0, ser_valid0, ser_out0, done0, sel0} !== 9'b100000000 ||
        {load_ready1, busy1, ser_valid1, ser_out1, done1, sel1} !== 9'b100000000) begin
      fails++;
      $display("FAIL async_reset got=%b/%b exp=100000000",
               {load_ready0, busy0, ser_valid0, ser_out0, done0, sel0},
               {load_ready1, busy1, ser_valid1, ser_out1, done1, sel1});
    end
    @(negedge clk);
    rst_n = 1'b1; ser_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      tests++;
      if (done0 !== 1'b0 || done1 !== 1'b0 || load_ready0 !== 1'b1) begin
        fails++;
        $display("FAIL reset_no_done got done=%b/%b ready=%b exp done=0/0 ready=1",
                 done0, done1, load_ready0);
      end
    end
    ser_ready = 1'b0;
    run_word(16'b1001101001101001, 1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fixed_word();
    test_backpressure();
    test_load_ignored();
    test_random();
    test_back_to_back();
    test_parity();
    test_clear();
    test_reset_midword();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
